// File: rtl/spin_update_engine_pkg.sv
// Shared types and default widths for the spin update engine and the dot-product chain feeding it.
package spin_update_engine_pkg;

    localparam int DEFAULT_VECTOR_SIZE     = 256;
    localparam int DEFAULT_J_ELEMENT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        UPDATE,
        DONE
    } state_e;

endpackage

// File: rtl/spin_update_engine.sv
// Sequential (Gauss-Seidel) spin update engine: requests one local field per column and updates sigma in place.
// Optional energy accumulator output enabled by defining SPIN_UPDATE_ENGINE_ENERGY_EN.
module spin_update_engine
    import spin_update_engine_pkg::*;
#(
    parameter int VECTOR_SIZE      = DEFAULT_VECTOR_SIZE,
    parameter int J_ELEMENT_WIDTH  = DEFAULT_J_ELEMENT_WIDTH,
    parameter int INT_RESULT_WIDTH = $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH,
    parameter int SWEEP_WIDTH      = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           start_i,
    input  logic [VECTOR_SIZE-1:0]                         sigma_init_i,
    input  logic [SWEEP_WIDTH-1:0]                         sweeps_i,
    output logic                                           col_req_valid_o,
    input  logic                                           col_req_ready_i,
    output logic [$clog2(VECTOR_SIZE)-1:0]                 col_idx_o,
    input  logic                                           field_valid_i,
    output logic                                           field_ready_o,
    input  logic signed [INT_RESULT_WIDTH-1:0]             field_i,
    output logic [VECTOR_SIZE-1:0]                         sigma_o,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic [$clog2(VECTOR_SIZE)+SWEEP_WIDTH-1:0]     flip_count_o
`ifdef SPIN_UPDATE_ENGINE_ENERGY_EN
    ,
    output logic signed [INT_RESULT_WIDTH+$clog2(VECTOR_SIZE)+SWEEP_WIDTH:0] energy_o
`endif
);

    localparam int IDX_W  = $clog2(VECTOR_SIZE);
    localparam int FLIP_W = IDX_W + SWEEP_WIDTH;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(VECTOR_SIZE - 1);

    state_e                             state;
    logic [SWEEP_WIDTH-1:0]             sweep_cnt;
    logic [SWEEP_WIDTH-1:0]             sweep_total;
    logic signed [INT_RESULT_WIDTH-1:0] field_q;
    logic                               new_spin;

    // Zero field leaves the spin alone; sign decides otherwise.
    always_comb begin
        new_spin = sigma_o[col_idx_o];
        if (field_q[INT_RESULT_WIDTH-1]) begin
            new_spin = 1'b0;
        end else if (field_q != '0) begin
            new_spin = 1'b1;
        end
    end

`ifdef SPIN_UPDATE_ENGINE_ENERGY_EN
    localparam int ENERGY_W = INT_RESULT_WIDTH + IDX_W + SWEEP_WIDTH + 1;
    logic [ENERGY_W-1:0] field_ext;
    assign field_ext = {{(ENERGY_W-INT_RESULT_WIDTH){field_q[INT_RESULT_WIDTH-1]}}, field_q};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            sigma_o         <= '0;
            flip_count_o    <= '0;
            col_idx_o       <= '0;
            sweep_cnt       <= '0;
            sweep_total     <= '0;
            field_q         <= '0;
            col_req_valid_o <= 1'b0;
            field_ready_o   <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
`ifdef SPIN_UPDATE_ENGINE_ENERGY_EN
            energy_o        <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        sigma_o      <= sigma_init_i;
                        flip_count_o <= '0;
                        col_idx_o    <= '0;
                        sweep_cnt    <= '0;
                        sweep_total  <= sweeps_i;
`ifdef SPIN_UPDATE_ENGINE_ENERGY_EN
                        energy_o     <= '0;
`endif
                        if (sweeps_i != '0) begin
                            state           <= REQ;
                            col_req_valid_o <= 1'b1;
                            busy_o          <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (col_req_ready_i) begin
                        col_req_valid_o <= 1'b0;
                        field_ready_o   <= 1'b1;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (field_valid_i) begin
                        field_q       <= field_i;
                        field_ready_o <= 1'b0;
                        state         <= UPDATE;
                    end
                end
                UPDATE: begin
                    sigma_o[col_idx_o] <= new_spin;
                    if ((new_spin != sigma_o[col_idx_o]) && (flip_count_o != '1)) begin
                        flip_count_o <= flip_count_o + FLIP_W'(1);
                    end
`ifdef SPIN_UPDATE_ENGINE_ENERGY_EN
                    if (new_spin) begin
                        energy_o <= energy_o + field_ext;
                    end else begin
                        energy_o <= energy_o - field_ext;
                    end
`endif
                    if (col_idx_o == LAST_COL) begin
                        col_idx_o <= '0;
                        if (sweep_cnt == sweep_total - SWEEP_WIDTH'(1)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            sweep_cnt       <= sweep_cnt + SWEEP_WIDTH'(1);
                            state           <= REQ;
                            col_req_valid_o <= 1'b1;
                        end
                    end else begin
                        col_idx_o       <= col_idx_o + IDX_W'(1);
                        state           <= REQ;
                        col_req_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
